// File: rtl/rriscv_pkg.sv
// Shared RV32 decode types: opcode/funct constants, the decoded entry record and stage states.
// Immediate and pc fields are sized for the widest supported datapath; narrower stages use the low bits.
package rriscv_pkg;

    localparam int XLEN     = 32;
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                rf_rw;
        logic                err;
        logic [XLEN_MAX-1:0] imm;
    } decoded_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: raw word + pc -> decoded_t, zero latency.
// Illegal words keep pc/opcode but report err with every register field and immediate cleared.
module decode_comb
    import rriscv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [XLEN_MAX-1:0] pc_i,
    input  logic [31:0]         instruction_i,
    output decoded_t            dec_o
);

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    decoded_t    d;

    assign ins = instruction_i;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    always_comb begin
        d        = '0;
        d.pc     = pc_i;
        d.opcode = ins[6:0];
        legal    = 1'b0;
        // Fields are only filled in for a recognised encoding, so illegal words stay zeroed.
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                OPC_OP: begin
                    if (f3 == F3_ADD && (f7 == F7_ADD || (ENABLE_M && f7 == F7_MUL))) begin
                        legal    = 1'b1;
                        d.rs1    = ins[19:15];
                        d.rs2    = ins[24:20];
                        d.rd     = ins[11:7];
                        d.funct3 = f3;
                        d.funct7 = f7;
                        d.rf_rw  = 1'b1;
                    end
                end
                OPC_OP_IMM, OPC_LOAD: begin
                    if ((ins[6:0] == OPC_OP_IMM && f3 == F3_ADDI) ||
                        (ins[6:0] == OPC_LOAD   && f3 == F3_LW)) begin
                        legal    = 1'b1;
                        d.rs1    = ins[19:15];
                        d.rd     = ins[11:7];
                        d.funct3 = f3;
                        d.rf_rw  = 1'b1;
                        d.imm    = sext32({{20{ins[31]}}, ins[31:20]});
                    end
                end
                OPC_STORE: begin
                    if (f3 == F3_SW) begin
                        legal    = 1'b1;
                        d.rs1    = ins[19:15];
                        d.rs2    = ins[24:20];
                        d.funct3 = f3;
                        d.imm    = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
                    end
                end
                OPC_BRANCH: begin
                    if (f3 == F3_BNE) begin
                        legal    = 1'b1;
                        d.rs1    = ins[19:15];
                        d.rs2    = ins[24:20];
                        d.funct3 = f3;
                        d.imm    = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                    end
                end
                OPC_JAL: begin
                    legal   = 1'b1;
                    d.rd    = ins[11:7];
                    d.rf_rw = 1'b1;
                    d.imm   = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                end
                OPC_LUI, OPC_AUIPC: begin
                    legal   = 1'b1;
                    d.rd    = ins[11:7];
                    d.rf_rw = 1'b1;
                    d.imm   = sext32({ins[31:12], 12'b0});
                end
                default: legal = 1'b0;
            endcase
        end
        d.err = !legal;
        dec_o = d;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: accepted entry appears on out_* one cycle later; a skid entry keeps
// full throughput, in_ready_o drops only when both entries are held. flush_i empties the stage.
module decode_stage #(
    parameter int XLEN      = rriscv_pkg::XLEN,
    parameter bit ENABLE_M  = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          instruction_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLEN-1:0]      pc_o,
    output logic [6:0]           opcode_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic [2:0]           funct3_o,
    output logic [6:0]           funct7_o,
    output logic                 rf_rw_o,
    output logic [XLEN-1:0]      immediate_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);
    import rriscv_pkg::*;

    stage_state_e          state_q, state_d;
    decoded_t              main_q, main_d;
    decoded_t              skid_q, skid_d;
    decoded_t              dec;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [XLEN_MAX-1:0]   pc_ext;
    logic                  accept;
    logic                  emit;
    logic                  unused_hi_bits;

    always_comb begin
        pc_ext = '0;
        pc_ext[XLEN-1:0] = pc_i;
    end

    decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
        .pc_i          (pc_ext),
        .instruction_i (instruction_i),
        .dec_o         (dec)
    );

    assign in_ready_o  = !rst_i && (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign accept      = in_valid_i && in_ready_o;
    assign emit        = out_valid_o && out_ready_i;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        err_cnt_d = err_cnt_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (accept && emit) begin
                        main_d = dec;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            // Counted on acceptance so a stalled illegal entry is counted exactly once.
            if (accept && dec.err && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pc_o        = main_q.pc[XLEN-1:0];
    assign opcode_o    = main_q.opcode;
    assign rs1_o       = main_q.rs1;
    assign rs2_o       = main_q.rs2;
    assign rd_o        = main_q.rd;
    assign funct3_o    = main_q.funct3;
    assign funct7_o    = main_q.funct7;
    assign rf_rw_o     = main_q.rf_rw;
    assign immediate_o = main_q.imm[XLEN-1:0];
    assign err_o       = main_q.err;
    assign err_count_o = err_cnt_q;

    // Upper pc/imm bits exist only for 64-bit builds.
    assign unused_hi_bits = ^{main_q.pc, main_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, backpressure ordering, flush and error counting.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready, out_valid, rf_rw, err;
    logic [31:0] pc_o, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [7:0]  err_count;

    logic        nm_in_ready, nm_out_valid, nm_rf_rw, nm_err;
    logic [31:0] nm_pc_o, nm_imm;
    logic [6:0]  nm_opcode, nm_funct7;
    logic [4:0]  nm_rs1, nm_rs2, nm_rd;
    logic [2:0]  nm_funct3;
    logic [7:0]  nm_err_count;

    logic        c2_in_ready, c2_out_valid, c2_rf_rw, c2_err;
    logic [31:0] c2_pc_o, c2_imm;
    logic [6:0]  c2_opcode, c2_funct7;
    logic [4:0]  c2_rs1, c2_rs2, c2_rd;
    logic [2:0]  c2_funct3;
    logic [1:0]  c2_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .instruction_i(instr), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .pc_o(pc_o), .opcode_o(opcode), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .funct3_o(funct3),
        .funct7_o(funct7), .rf_rw_o(rf_rw), .immediate_o(imm), .err_o(err), .err_count_o(err_count)
    );

    decode_stage #(.ENABLE_M(1'b0)) dut_nm (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(nm_in_ready),
        .pc_i(pc), .instruction_i(instr), .out_valid_o(nm_out_valid), .out_ready_i(out_ready),
        .pc_o(nm_pc_o), .opcode_o(nm_opcode), .rs1_o(nm_rs1), .rs2_o(nm_rs2), .rd_o(nm_rd),
        .funct3_o(nm_funct3), .funct7_o(nm_funct7), .rf_rw_o(nm_rf_rw), .immediate_o(nm_imm),
        .err_o(nm_err), .err_count_o(nm_err_count)
    );

    decode_stage #(.ENABLE_M(1'b0), .ERR_CNT_W(2)) dut_c2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(c2_in_ready),
        .pc_i(pc), .instruction_i(instr), .out_valid_o(c2_out_valid), .out_ready_i(out_ready),
        .pc_o(c2_pc_o), .opcode_o(c2_opcode), .rs1_o(c2_rs1), .rs2_o(c2_rs2), .rd_o(c2_rd),
        .funct3_o(c2_funct3), .funct7_o(c2_funct7), .rf_rw_o(c2_rf_rw), .immediate_o(c2_imm),
        .err_o(c2_err), .err_count_o(c2_err_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pc        = '0;
        instr     = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw;
        logic        err;
        logic [31:0] imm;
        logic        err_nm;
    } vec_t;

    localparam logic [31:0] ILL_LOW = 32'h0000_0010;
    localparam logic [31:0] ADDI_W  = 32'hFFF0_0093;

    vec_t        vecs[13];
    logic [31:0] emitted[$];
    int          accepted;
    int          idx;
    logic [31:0] exp_pc;

    initial begin
        // instr, rs1, rs2, rd, f3, f7, rf_rw, err, imm, err with ENABLE_M=0
        vecs[0]  = '{32'hFFF00093, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h123450B7, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 1'b1, 1'b0, 32'h12345000, 1'b0};
        vecs[2]  = '{32'hFE209EE3, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h02208033, 5'd1, 5'd2, 5'd0, 3'd0, 7'd1, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vecs[4]  = '{32'h002081B3, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{32'h0020A423, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 1'b0, 1'b0, 32'h00000008, 1'b0};
        vecs[6]  = '{32'hFF812283, 5'd2, 5'd0, 5'd5, 3'd2, 7'd0, 1'b1, 1'b0, 32'hFFFFFFF8, 1'b0};
        vecs[7]  = '{32'h010000EF, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 1'b1, 1'b0, 32'h00000010, 1'b0};
        vecs[8]  = '{32'hFFFFF117, 5'd0, 5'd0, 5'd2, 3'd0, 7'd0, 1'b1, 1'b0, 32'hFFFFF000, 1'b0};
        vecs[9]  = '{32'h00109093, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1, 32'h00000000, 1'b1};
        vecs[10] = '{ILL_LOW,      5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1, 32'h00000000, 1'b1};
        vecs[11] = '{32'h402081B3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1, 32'h00000000, 1'b1};
        vecs[12] = '{32'hFE208EE3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 1'b1, 32'h00000000, 1'b1};

        // Reset values, including in_ready low while reset is held.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pc = '0; instr = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_imm", imm, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Decode table, one entry at a time with downstream always ready.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            pc       = 32'h100 + 32'(4 * i);
            exp_pc   = pc;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_pc", i), pc_o, exp_pc);
            chk($sformatf("v%0d_opcode", i), opcode, vecs[i].instr & 32'h7F);
            chk($sformatf("v%0d_rs1", i), rs1, vecs[i].rs1);
            chk($sformatf("v%0d_rs2", i), rs2, vecs[i].rs2);
            chk($sformatf("v%0d_rd", i), rd, vecs[i].rd);
            chk($sformatf("v%0d_f3", i), funct3, vecs[i].f3);
            chk($sformatf("v%0d_f7", i), funct7, vecs[i].f7);
            chk($sformatf("v%0d_rf_rw", i), rf_rw, vecs[i].rw);
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_err", i), err, vecs[i].err);
            chk($sformatf("v%0d_err_nm", i), nm_err, vecs[i].err_nm);
            if (vecs[i].err_nm) chk($sformatf("v%0d_rf_rw_nm", i), nm_rf_rw, 0);
        end
        chk("cnt_m1", err_count, 4);
        chk("cnt_m0", nm_err_count, 5);
        chk("cnt_sat_w2", c2_err_count, 3);

        // Reset mid-operation clears the counter.
        do_reset();
        chk("mid_rst_cnt", err_count, 0);
        chk("mid_rst_cnt_w2", c2_err_count, 0);
        chk("mid_rst_valid", out_valid, 0);

        // MUL with and without the M extension, counter 0 -> 1 on the M-less instance.
        @(negedge clk);
        in_valid = 1'b1; instr = 32'h02208033; pc = 32'h200;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_m1_err", err, 0);
        chk("mul_m0_err", nm_err, 1);
        chk("mul_m0_rf_rw", nm_rf_rw, 0);
        chk("mul_m0_cnt", nm_err_count, 1);
        chk("mul_m1_cnt", err_count, 0);

        // Backpressure: three back-to-back offers, two held, then drained in order.
        do_reset();
        out_ready = 1'b0;
        accepted  = 0;
        idx       = 0;
        emitted.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc == 3) out_ready = 1'b1;
            in_valid = (idx < 3);
            instr    = ADDI_W;
            pc       = 32'(4 * idx);
            if (cyc == 2) begin
                chk("bp_in_ready_full", in_ready, 0);
                chk("bp_accepted", accepted, 2);
                chk("bp_hold_pc", pc_o, 0);
            end
            if (out_valid && out_ready) emitted.push_back(pc_o);
            if (in_valid && in_ready) begin
                accepted++;
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("bp_emit_count", emitted.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_emit_pc%0d", k), (k < emitted.size()) ? emitted[k] : 32'hDEAD, 32'(4 * k));
        end

        // Flush while two entries are held, with an illegal word offered.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = ILL_LOW; pc = 32'h40;
        @(negedge clk);
        instr = ADDI_W; pc = 32'h44;
        @(negedge clk);
        chk("fl2_full", in_ready, 0);
        instr = ILL_LOW; pc = 32'h48; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_valid", out_valid, 0);
        chk("fl2_in_ready", in_ready, 1);
        chk("fl2_cnt", err_count, 1);

        // Flush in the same cycle as an accepted illegal word: dropped and not counted.
        in_valid = 1'b1; instr = ADDI_W; pc = 32'h50;
        @(negedge clk);
        instr = ILL_LOW; pc = 32'h54; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", out_valid, 0);
        chk("fl1_cnt", err_count, 1);
        out_ready = 1'b1;
        in_valid = 1'b1; instr = ADDI_W; pc = 32'h58;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_pc", pc_o, 32'h58);
        chk("fl_after_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
